// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC serial-link frame receiver.
// Frame layout (MSB first): [15:14] don't-care, [13:12] power-down mode, [11:0] DAC code.
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS_DEF  = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned PD_LSB = 12;
    localparam int unsigned PD_MSB = 13;

    typedef enum logic [1:0] {
        PD_NORMAL = 2'b00,
        PD_1K     = 2'b01,
        PD_100K   = 2'b10,
        PD_HIZ    = 2'b11
    } pd_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } rx_state_t;

    // Increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dac_spi_rx_if.sv
// Serial-link inputs and received-frame output handshake of dac_spi_rx.
// DAC_RX_STATS_EN adds the frame_cnt / err_cnt statistics outputs.
interface dac_spi_rx_if;

    logic                            sclk;
    logic                            sync;
    logic                            dac_din;
    logic [dac_spi_pkg::DATA_W-1:0]  out_data;
    logic [1:0]                      out_pd;
    logic                            out_valid;
    logic                            out_ready;
    logic                            frame_err;
    logic                            timeout_err;
    logic                            overrun;
`ifdef DAC_RX_STATS_EN
    logic [15:0]                     frame_cnt;
    logic [15:0]                     err_cnt;
`endif

    // Receiver side
    modport slave (
        input  sclk, sync, dac_din, out_ready,
        output out_data, out_pd, out_valid, frame_err, timeout_err, overrun
`ifdef DAC_RX_STATS_EN
        , output frame_cnt, err_cnt
`endif
    );

    // Link driver / frame consumer side
    modport master (
        output sclk, sync, dac_din, out_ready,
        input  out_data, out_pd, out_valid, frame_err, timeout_err, overrun
`ifdef DAC_RX_STATS_EN
        , input frame_cnt, err_cnt
`endif
    );

endinterface

// File: rtl/dac_spi_rx_edge_sync.sv
// Multi-flop synchroniser for one asynchronous line, with rise/fall detect
// against a one-cycle delayed copy of the synchronised level.
module spi_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic [STAGES:0]   settle_q;

    // Chain and delayed copy load idle-high; edges are masked until the chain
    // has been refilled from the pin after reset, so a line already low at
    // reset release does not look like a fresh falling edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            chain_q  <= '1;
            prev_q   <= 1'b1;
            settle_q <= '0;
        end else begin
            chain_q  <= {chain_q[STAGES-2:0], async_in};
            prev_q   <= chain_q[STAGES-1];
            settle_q <= {settle_q[STAGES-1:0], 1'b1};
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = settle_q[STAGES] &  chain_q[STAGES-1] & ~prev_q;
    assign fall  = settle_q[STAGES] & ~chain_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// Receiver for 16-bit DAC serial frames observed on sclk/sync/dac_din,
// oversampled on clk_in and presented on a valid/ready output register.
// Optional build macro: DAC_RX_STATS_EN (adds frame_cnt / err_cnt).
module dac_spi_rx
    import dac_spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic         clk_in,
    input  logic         rst,
    dac_spi_rx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic sclk_fall, sclk_level_unused, sclk_rise_unused;
    logic sync_s, sync_rise, sync_fall;
    logic din_s, din_rise_unused, din_fall_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_in(clk_in), .rst(rst), .async_in(bus.sclk),
        .level(sclk_level_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .clk_in(clk_in), .rst(rst), .async_in(bus.sync),
        .level(sync_s), .rise(sync_rise), .fall(sync_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
        .clk_in(clk_in), .rst(rst), .async_in(bus.dac_din),
        .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    rx_state_t              state_q, state_n;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic                   frame_done_q, frame_err_q, timeout_err_q;
    logic                   clear_cnt, do_shift, tmo_inc, done_n, ferr_n, terr_n;

    // Leading don't-care bits of the frame; shifted through but never decoded.
    logic [FRAME_BITS-PD_MSB-2:0] hdr_unused;
    assign hdr_unused = shift_q[FRAME_BITS-1:PD_MSB+1];

    // Frame state register.
    always_ff @(posedge clk_in) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state and datapath controls for the frame FSM.
    always_comb begin
        state_n   = state_q;
        clear_cnt = 1'b0;
        do_shift  = 1'b0;
        tmo_inc   = 1'b0;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        terr_n    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_fall) begin
                    state_n   = SHIFT;
                    clear_cnt = 1'b1;
                end
            end
            SHIFT: begin
                if (sync_rise) begin
                    ferr_n  = 1'b1;
                    state_n = IDLE;
                end else if (sclk_fall && !sync_s) begin
                    do_shift = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        done_n  = 1'b1;
                        state_n = HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    terr_n  = 1'b1;
                    state_n = HOLD;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            HOLD: begin
                if (sync_rise) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift register, bit/timeout counters and registered event pulses.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_done_q  <= done_n;
            frame_err_q   <= ferr_n;
            timeout_err_q <= terr_n;
            if (clear_cnt) begin
                bit_cnt_q <= '0;
                tmo_q     <= '0;
            end else if (do_shift) begin
                shift_q   <= {shift_q[FRAME_BITS-2:0], din_s};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                tmo_q     <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] data_q;
    logic [1:0]        pd_q;
    logic              valid_q, overrun_q;

    // Output register: load on frame_done when empty or being drained this
    // cycle, otherwise drop the new frame and flag overrun.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            data_q    <= '0;
            pd_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_done_q) begin
                if (!valid_q || bus.out_ready) begin
                    data_q  <= shift_q[DATA_W-1:0];
                    pd_q    <= shift_q[PD_MSB:PD_LSB];
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_pd      = pd_q;
    assign bus.out_valid   = valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;

`ifdef DAC_RX_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    // Saturating counters of completed frames (overruns included) and errors.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done_q)                 frame_cnt_q <= sat_inc16(frame_cnt_q);
            if (frame_err_q || timeout_err_q) err_cnt_q   <= sat_inc16(err_cnt_q);
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// Self-checking bench for dac_spi_rx: directed frames plus random frames,
// compared against a frame-level model of accepted words and event counts.
module tb_dac_spi_rx;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    dac_spi_rx_if bus ();

    dac_spi_rx #(
        .FRAME_BITS(16),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(1000)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_in) cyc++;

    // Monitor: records accepted words, pulse counts and out_valid rise times.
    logic [13:0] acc_q[$];
    int mon_fe = 0, mon_to = 0, mon_ov = 0, mon_vhi = 0;
    int rise_cyc = -1000;
    logic prev_valid = 1'b0;

    always @(negedge clk_in) begin
        if (bus.out_valid && bus.out_ready) acc_q.push_back({bus.out_pd, bus.out_data});
        if (bus.frame_err)   mon_fe++;
        if (bus.timeout_err) mon_to++;
        if (bus.overrun)     mon_ov++;
        if (bus.out_valid)   mon_vhi++;
        if (bus.out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.out_valid;
    end

    // Reference model state.
    logic [13:0] exp_q[$];
    int          acc_rd = 0, exp_rd = 0;
    bit          rdy = 1'b0;
    bit          exp_valid = 1'b0;
    logic [13:0] exp_word = '0;
    int          exp_fe = 0, exp_to = 0, exp_ov = 0, exp_fc = 0, exp_ec = 0;
    int          last_fall_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic set_ready(input bit v);
        bus.out_ready = v;
        rdy = v;
        if (v && exp_valid) begin
            exp_q.push_back(exp_word);
            exp_valid = 1'b0;
        end
    endtask

    task automatic clock_bits(input logic [15:0] w, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            bus.dac_din = w[15 - i];
            tick(10);
            bus.sclk = 1'b0;
            last_fall_cyc = cyc;
            tick(10);
            bus.sclk = 1'b1;
        end
    endtask

    task automatic model_complete(input logic [15:0] w);
        exp_fc++;
        if (rdy) begin
            exp_q.push_back(w[13:0]);
        end else if (exp_valid) begin
            exp_ov++;
        end else begin
            exp_valid = 1'b1;
            exp_word  = w[13:0];
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits);
        bit rise_exp;
        rise_exp = (nbits == 16) && (rdy || !exp_valid);
        bus.sync = 1'b0;
        tick(4);
        clock_bits(w, 0, nbits);
        tick(3);
        bus.sync = 1'b1;
        tick(10);
        if (nbits < 16) begin
            exp_fe++;
            exp_ec++;
        end else begin
            model_complete(w);
        end
        if (rise_exp) chk("latency", 32'(rise_cyc - last_fall_cyc), 32'd4);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/acc_cnt"}, 32'(acc_q.size() - acc_rd), 32'(exp_q.size() - exp_rd));
        while (acc_rd < acc_q.size() && exp_rd < exp_q.size()) begin
            chk({tag, "/acc_word"}, 32'(acc_q[acc_rd]), 32'(exp_q[exp_rd]));
            acc_rd++;
            exp_rd++;
        end
        acc_rd = acc_q.size();
        exp_rd = exp_q.size();
        chk({tag, "/frame_err_cnt"}, mon_fe, exp_fe);
        chk({tag, "/timeout_cnt"},   mon_to, exp_to);
        chk({tag, "/overrun_cnt"},   mon_ov, exp_ov);
        chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk({tag, "/out_data"}, 32'(bus.out_data), 32'(exp_word[11:0]));
            chk({tag, "/out_pd"},   32'(bus.out_pd),   32'(exp_word[13:12]));
        end
`ifdef DAC_RX_STATS_EN
        chk({tag, "/frame_cnt"}, 32'(bus.frame_cnt), 32'(exp_fc));
        chk({tag, "/err_cnt"},   32'(bus.err_cnt),   32'(exp_ec));
`endif
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        logic [15:0] w;
        int nb;

        bus.sclk      = 1'b1;
        bus.sync      = 1'b1;
        bus.dac_din   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(5);

        // Reset values
        chk("rst/out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst/out_data",    32'(bus.out_data),    32'd0);
        chk("rst/out_pd",      32'(bus.out_pd),      32'd0);
        chk("rst/frame_err",   32'(bus.frame_err),   32'd0);
        chk("rst/timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst/overrun",     32'(bus.overrun),     32'd0);
        rst = 1'b0;
        tick(5);

        // 0x0ABC with ready high: single-cycle valid
        set_ready(1'b1);
        v0 = mon_vhi;
        send_frame(16'h0ABC, 16);
        chk("abc/valid_cycles", 32'(mon_vhi - v0), 32'd1);
        check_state("abc");

        // 0x3FFF with ready low: held until ready
        set_ready(1'b0);
        send_frame(16'h3FFF, 16);
        check_state("fff_held");
        tick(50);
        check_state("fff_still_held");
        set_ready(1'b1);
        tick(3);
        check_state("fff_drained");

        // Overrun: second frame dropped while first is held
        set_ready(1'b0);
        send_frame(16'h0123, 16);
        send_frame(16'h0456, 16);
        check_state("overrun");
        set_ready(1'b1);
        tick(3);
        check_state("overrun_drained");

        // Short frame then a good one
        send_frame(16'h5A5A, 9);
        check_state("short9");
        send_frame(16'h0001, 16);
        check_state("after_short");

        // sclk stall mid-frame: timeout, trailing clocks ignored
        bus.sync = 1'b0;
        tick(4);
        clock_bits(16'h0F0F, 0, 5);
        tick(1200);
        clock_bits(16'h0F0F, 5, 11);
        tick(3);
        bus.sync = 1'b1;
        tick(10);
        exp_to++;
        exp_ec++;
        check_state("timeout");

        // Reset mid-frame; remainder of that frame must not be captured
        bus.sync = 1'b0;
        tick(4);
        clock_bits(16'h0FFF, 0, 8);
        rst = 1'b1;
        tick(3);
        chk("midrst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst/out_data",  32'(bus.out_data),  32'd0);
        chk("midrst/out_pd",    32'(bus.out_pd),    32'd0);
        exp_valid = 1'b0;
        exp_fc = 0;
        exp_ec = 0;
        rst = 1'b0;
        tick(5);
        clock_bits(16'h0FFF, 8, 8);
        tick(3);
        bus.sync = 1'b1;
        tick(10);
        check_state("midrst_tail");
        send_frame(16'h0800, 16);
        check_state("after_rst");

        // Random frames, random ready, occasional short frames and drains
        for (int n = 0; n < 16; n++) begin
            set_ready(1'($urandom_range(0, 1)));
            tick(2);
            w  = 16'($urandom);
            nb = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 15)) : 16;
            send_frame(w, nb);
            check_state("rand");
            if ($urandom_range(0, 1) == 1) begin
                set_ready(1'b1);
                tick(3);
                check_state("rand_drain");
            end
        end

        set_ready(1'b1);
        tick(3);
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
